// File: rtl/pia_fifo_pkg.sv
// Shared types for the PIA <-> FT245 bridge.
//  eng_state_t : FT245 strobe engine states
//  served_t    : which direction the engine served last (drives the
//                alternating arbitration when both directions are ready)
//  max3        : helper used to size the shared timing counter
package pia_fifo_pkg;

   typedef enum logic [2:0] {
      ENG_IDLE     = 3'd0,
      ENG_RD_LOW   = 3'd1,
      ENG_RD_REC   = 3'd2,
      ENG_WR_SETUP = 3'd3,
      ENG_WR_LOW   = 3'd4,
      ENG_WR_HOLD  = 3'd5,
      ENG_WR_REC   = 3'd6
   } eng_state_t;

   typedef enum logic {
      SRV_READ  = 1'b0,
      SRV_WRITE = 1'b1
   } served_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/pia_fifo_bridge_if.sv
// PIA and FT245 handshake signals of the bridge, grouped.
//  slave  : the bridge side (takes PIA/FIFO status, drives flags and strobes)
//  master : the environment side (PIA pins and USB FIFO status pins)
// The FT245 data bus is bidirectional and stays a plain inout on the bridge.
interface pia_fifo_bridge_if #(
   parameter int DATA_W = 7
);
   logic              pia_e;
   logic              pia_ca1;
   logic              pia_ca2;
   logic [DATA_W-1:0] pia_pa;
   logic              pia_cb1;
   logic              pia_cb2;
   logic [DATA_W-1:0] pia_pb;
   logic              pia_da;
   logic              fifo_rxf;
   logic              fifo_txe;
   logic              fifo_rd;
   logic              fifo_wr;
   logic              tx_overflow;

   modport slave (
      input  pia_e, pia_ca2, pia_cb2, pia_pb, fifo_rxf, fifo_txe,
      output pia_ca1, pia_pa, pia_cb1, pia_da, fifo_rd, fifo_wr, tx_overflow
   );

   modport master (
      output pia_e, pia_ca2, pia_cb2, pia_pb, fifo_rxf, fifo_txe,
      input  pia_ca1, pia_pa, pia_cb1, pia_da, fifo_rd, fifo_wr, tx_overflow
   );
endinterface

// File: rtl/bridge_fifo.sv
// Small synchronous FIFO used for the RX and TX character buffers.
// Ports:
//  clk, reset       clock, synchronous active-low reset
//  push, push_data  write request and data
//  pop              read request (head advances)
//  full, empty      status
//  head             current head entry (valid when !empty)
// A push on a full buffer is accepted when a pop happens in the same cycle;
// a pop on an empty buffer is ignored.
module bridge_fifo #(
   parameter int WIDTH = 7,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign head    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/pia_fifo_bridge.sv
// Bridge between the 6821 PIA (keyboard port A, display port B) and an
// FT245-style USB FIFO, with RX/TX buffering and a timed strobe engine.
// Ports:
//  clk, reset   clock, synchronous active-low reset
//  bus          PIA flags/strobes and FT245 status/strobes (slave modport)
//  fifo_data    FT245 data bus, driven only during the write phases
//
// state        | meaning
// -------------+-----------------------------------------------------
// ENG_IDLE     | sample rxf/txe, arbitrate read vs write
// ENG_RD_LOW   | fifo_rd low, data captured on last low cycle
// ENG_RD_REC   | fifo_rd high recovery
// ENG_WR_SETUP | TX head on fifo_data before fifo_wr falls
// ENG_WR_LOW   | fifo_wr low, data driven
// ENG_WR_HOLD  | fifo_wr high, data still driven for one cycle
// ENG_WR_REC   | bus released, recovery before next transfer
module pia_fifo_bridge
   import pia_fifo_pkg::*;
#(
   parameter int DATA_W         = 7,
   parameter int RX_DEPTH       = 4,
   parameter int TX_DEPTH       = 4,
   parameter int STROBE_CYCLES  = 2,
   parameter int SETUP_CYCLES   = 1,
   parameter int RECOVER_CYCLES = 1
) (
   input  logic              clk,
   input  logic              reset,
   pia_fifo_bridge_if.slave  bus,
   inout  wire [DATA_W-1:0]  fifo_data
);
   localparam int CNT_MAX = max3(STROBE_CYCLES, SETUP_CYCLES, RECOVER_CYCLES);
   localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

   localparam logic [CNT_W-1:0] LD_STROBE  = CNT_W'(STROBE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LD_SETUP   = CNT_W'(SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] LD_RECOVER = CNT_W'(RECOVER_CYCLES - 1);

   eng_state_t        state, state_n;
   served_t           last, last_n;
   logic [CNT_W-1:0]  cnt, cnt_n;

   logic              e_s;
   logic              ca2_s, ca2_p, cb2_s, cb2_p;
   logic              rxf_s, txe_s;
   logic              ca2_edge, cb2_edge;

   logic              rx_push, rx_full, rx_empty;
   logic [DATA_W-1:0] rx_head;
   logic              tx_pop, tx_full, tx_empty, tx_push_ok;
   logic [DATA_W-1:0] tx_head;

   logic              ca1_q, cb1_q, da_q, ovf_q;
   logic [DATA_W-1:0] pa_q;
   logic [DATA_W-1:0] dout_q;
   logic              oe_q, rd_q, wr_q;

   assign ca2_edge   = ca2_s && !ca2_p;
   assign cb2_edge   = cb2_s && !cb2_p;
   // A push on a full TX is still taken when the engine pops that cycle.
   assign tx_push_ok = cb2_edge && (!tx_full || tx_pop);

   bridge_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx (
      .clk       (clk),
      .reset     (reset),
      .push      (rx_push),
      .push_data (fifo_data),
      .pop       (ca2_edge),
      .full      (rx_full),
      .empty     (rx_empty),
      .head      (rx_head)
   );

   bridge_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx (
      .clk       (clk),
      .reset     (reset),
      .push      (cb2_edge),
      .push_data (bus.pia_pb),
      .pop       (tx_pop),
      .full      (tx_full),
      .empty     (tx_empty),
      .head      (tx_head)
   );

   always_comb begin
      state_n = state;
      last_n  = last;
      cnt_n   = (cnt == '0) ? '0 : cnt - 1'b1;
      rx_push = 1'b0;
      tx_pop  = 1'b0;
      unique case (state)
         ENG_IDLE: begin
            if (!rxf_s && !rx_full && (txe_s || tx_empty || last == SRV_WRITE)) begin
               state_n = ENG_RD_LOW;
               cnt_n   = LD_STROBE;
               last_n  = SRV_READ;
            end else if (!txe_s && !tx_empty) begin
               state_n = ENG_WR_SETUP;
               cnt_n   = LD_SETUP;
               last_n  = SRV_WRITE;
               tx_pop  = 1'b1;
            end
         end
         ENG_RD_LOW: begin
            if (cnt == '0) begin
               rx_push = 1'b1;
               state_n = ENG_RD_REC;
               cnt_n   = LD_RECOVER;
            end
         end
         ENG_RD_REC: begin
            if (cnt == '0) state_n = ENG_IDLE;
         end
         ENG_WR_SETUP: begin
            if (cnt == '0) begin
               state_n = ENG_WR_LOW;
               cnt_n   = LD_STROBE;
            end
         end
         ENG_WR_LOW: begin
            if (cnt == '0) state_n = ENG_WR_HOLD;
         end
         ENG_WR_HOLD: begin
            state_n = ENG_WR_REC;
            cnt_n   = LD_RECOVER;
         end
         ENG_WR_REC: begin
            if (cnt == '0) state_n = ENG_IDLE;
         end
         default: state_n = ENG_IDLE;
      endcase
   end

   // Strobes and bus enable are registered from the next state so the
   // pins change cleanly on the same edge as the state register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= ENG_IDLE;
         last   <= SRV_WRITE;
         cnt    <= '0;
         e_s    <= 1'b1;
         ca2_s  <= 1'b0;
         ca2_p  <= 1'b0;
         cb2_s  <= 1'b0;
         cb2_p  <= 1'b0;
         rxf_s  <= 1'b1;
         txe_s  <= 1'b1;
         ca1_q  <= 1'b0;
         cb1_q  <= 1'b0;
         pa_q   <= '0;
         da_q   <= 1'b0;
         ovf_q  <= 1'b0;
         dout_q <= '0;
         oe_q   <= 1'b0;
         rd_q   <= 1'b1;
         wr_q   <= 1'b1;
      end else begin
         state  <= state_n;
         last   <= last_n;
         cnt    <= cnt_n;
         e_s    <= bus.pia_e;
         ca2_s  <= bus.pia_ca2;
         ca2_p  <= ca2_s;
         cb2_s  <= bus.pia_cb2;
         cb2_p  <= cb2_s;
         rxf_s  <= bus.fifo_rxf;
         txe_s  <= bus.fifo_txe;

         if (ca2_edge)               ca1_q <= 1'b0;
         else if (rx_empty)          ca1_q <= 1'b0;
         else if (!e_s)              ca1_q <= 1'b1;

         if (tx_push_ok)             cb1_q <= 1'b0;
         else if (!e_s && !tx_full)  cb1_q <= 1'b1;

         if (cb2_edge && !tx_push_ok) ovf_q <= 1'b1;

         pa_q   <= rx_empty ? '0 : rx_head;
         da_q   <= tx_full;
         if (tx_pop) dout_q <= tx_head;
         oe_q   <= (state_n == ENG_WR_SETUP) || (state_n == ENG_WR_LOW) ||
                   (state_n == ENG_WR_HOLD);
         rd_q   <= (state_n != ENG_RD_LOW);
         wr_q   <= (state_n != ENG_WR_LOW);
      end
   end

   assign fifo_data       = oe_q ? dout_q : 'z;
   assign bus.pia_ca1     = ca1_q;
   assign bus.pia_cb1     = cb1_q;
   assign bus.pia_pa      = pa_q;
   assign bus.pia_da      = da_q;
   assign bus.tx_overflow = ovf_q;
   assign bus.fifo_rd     = rd_q;
   assign bus.fifo_wr     = wr_q;

endmodule

// File: tb/tb_pia_fifo_bridge.sv
// Directed bench for pia_fifo_bridge with default parameters.
module tb_pia_fifo_bridge;
   localparam int DW = 7;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   pia_fifo_bridge_if #(.DATA_W(DW)) bus ();
   wire [DW-1:0] fifo_data;

   logic          tb_oe;
   logic          tb_probe;
   logic [DW-1:0] tb_rd_data;
   logic [DW-1:0] tb_probe_val;
   wire           tb_drive = tb_probe | (tb_oe & ~bus.fifo_rd);
   wire [DW-1:0]  tb_val   = tb_probe ? tb_probe_val : tb_rd_data;
   assign fifo_data = tb_drive ? tb_val : 'z;

   int checks = 0;
   int errors = 0;

   pia_fifo_bridge dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .fifo_data (fifo_data)
   );

   task automatic init_inputs();
      bus.pia_e    = 1'b1;
      bus.pia_ca2  = 1'b0;
      bus.pia_cb2  = 1'b0;
      bus.pia_pb   = '0;
      bus.fifo_rxf = 1'b1;
      bus.fifo_txe = 1'b1;
      tb_oe        = 1'b0;
      tb_probe     = 1'b0;
      tb_rd_data   = '0;
      tb_probe_val = 7'h2A;
   endtask

   task automatic do_reset();
      init_inputs();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic push_tx(input logic [DW-1:0] v);
      bus.pia_pb  = v;
      bus.pia_cb2 = 1'b1;
      repeat (3) @(negedge clk);
      bus.pia_cb2 = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic fifo_read(input logic [DW-1:0] v);
      int n;
      tb_oe        = 1'b1;
      tb_rd_data   = v;
      bus.fifo_rxf = 1'b0;
      n = 0;
      while (bus.fifo_rd !== 1'b0 && n < 50) begin @(negedge clk); n++; end
      bus.fifo_rxf = 1'b1;
      checks++;
      if (bus.fifo_rd !== 1'b0) begin
         errors++;
         $display("FAIL read_start: fifo_rd=%b expected 0 within 50 cycles", bus.fifo_rd);
      end
      n = 0;
      while (bus.fifo_rd !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      repeat (2) @(negedge clk);
      tb_oe = 1'b0;
   endtask

   task automatic test_reset();
      init_inputs();
      reset    = 1'b0;
      tb_probe = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (bus.pia_ca1 !== 1'b0) begin errors++; $display("FAIL rst_ca1: got %b expected 0", bus.pia_ca1); end
      checks++; if (bus.pia_cb1 !== 1'b0) begin errors++; $display("FAIL rst_cb1: got %b expected 0", bus.pia_cb1); end
      checks++; if (bus.pia_pa !== 7'h00) begin errors++; $display("FAIL rst_pa: got %h expected 00", bus.pia_pa); end
      checks++; if (bus.pia_da !== 1'b0) begin errors++; $display("FAIL rst_da: got %b expected 0", bus.pia_da); end
      checks++; if (bus.fifo_rd !== 1'b1) begin errors++; $display("FAIL rst_rd: got %b expected 1", bus.fifo_rd); end
      checks++; if (bus.fifo_wr !== 1'b1) begin errors++; $display("FAIL rst_wr: got %b expected 1", bus.fifo_wr); end
      checks++; if (bus.tx_overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b expected 0", bus.tx_overflow); end
      checks++; if (fifo_data !== 7'h2A) begin errors++; $display("FAIL rst_bus_released: got %h expected 2a", fifo_data); end
      tb_probe  = 1'b0;
      reset     = 1'b1;
      bus.pia_e = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (bus.pia_cb1 !== 1'b1) begin errors++; $display("FAIL cb1_after_reset: got %b expected 1", bus.pia_cb1); end
      checks++; if (bus.pia_ca1 !== 1'b0) begin errors++; $display("FAIL ca1_rx_empty: got %b expected 0", bus.pia_ca1); end
      bus.pia_e = 1'b1;
   endtask

   task automatic test_reset_mid_write();
      int n;
      do_reset();
      push_tx(7'h55);
      bus.fifo_txe = 1'b0;
      n = 0;
      while (bus.fifo_wr !== 1'b0 && n < 50) begin @(negedge clk); n++; end
      checks++;
      if (bus.fifo_wr !== 1'b0) begin errors++; $display("FAIL midwr_reach: fifo_wr=%b expected 0 within 50 cycles", bus.fifo_wr); end
      reset        = 1'b0;
      tb_probe     = 1'b1;
      bus.fifo_txe = 1'b1;
      @(negedge clk);
      checks++; if (bus.fifo_wr !== 1'b1) begin errors++; $display("FAIL midwr_wr: got %b expected 1", bus.fifo_wr); end
      checks++; if (fifo_data !== 7'h2A) begin errors++; $display("FAIL midwr_bus: got %h expected 2a (released)", fifo_data); end
      checks++; if (bus.pia_da !== 1'b0) begin errors++; $display("FAIL midwr_da: got %b expected 0", bus.pia_da); end
      checks++; if (bus.pia_ca1 !== 1'b0) begin errors++; $display("FAIL midwr_ca1: got %b expected 0", bus.pia_ca1); end
      tb_probe = 1'b0;
      reset    = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_rx_read();
      int n;
      int lowc;
      do_reset();
      tb_oe        = 1'b1;
      tb_rd_data   = 7'h41;
      bus.fifo_rxf = 1'b0;
      n = 0;
      while (bus.fifo_rd !== 1'b0 && n < 50) begin @(negedge clk); n++; end
      bus.fifo_rxf = 1'b1;
      lowc = 0;
      while (bus.fifo_rd === 1'b0 && lowc < 20) begin lowc++; @(negedge clk); end
      checks++; if (lowc != 2) begin errors++; $display("FAIL rd_low_cycles: got %0d expected 2", lowc); end
      tb_oe = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (bus.pia_pa !== 7'h41) begin errors++; $display("FAIL rd_pa: got %h expected 41", bus.pia_pa); end
      checks++; if (bus.pia_ca1 !== 1'b0) begin errors++; $display("FAIL rd_ca1_e_high: got %b expected 0", bus.pia_ca1); end
      bus.pia_e = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (bus.pia_ca1 !== 1'b1) begin errors++; $display("FAIL rd_ca1_e_low: got %b expected 1", bus.pia_ca1); end
      bus.pia_e = 1'b1;
   endtask

   task automatic test_rx_pop();
      do_reset();
      bus.pia_e = 1'b0;
      fifo_read(7'h31);
      fifo_read(7'h32);
      repeat (2) @(negedge clk);
      checks++; if (bus.pia_pa !== 7'h31) begin errors++; $display("FAIL pop_head0: got %h expected 31", bus.pia_pa); end
      checks++; if (bus.pia_ca1 !== 1'b1) begin errors++; $display("FAIL pop_ca1_before: got %b expected 1", bus.pia_ca1); end
      bus.pia_e   = 1'b1;
      bus.pia_ca2 = 1'b1;
      repeat (3) @(negedge clk);
      bus.pia_ca2 = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (bus.pia_ca1 !== 1'b0) begin errors++; $display("FAIL pop_ca1_drop: got %b expected 0", bus.pia_ca1); end
      checks++; if (bus.pia_pa !== 7'h32) begin errors++; $display("FAIL pop_head1: got %h expected 32", bus.pia_pa); end
      bus.pia_e = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (bus.pia_ca1 !== 1'b1) begin errors++; $display("FAIL pop_ca1_return: got %b expected 1", bus.pia_ca1); end
      bus.pia_e = 1'b1;
   endtask

   task automatic test_tx_overflow();
      logic [DW-1:0] vals [5];
      int n;
      int extra;
      vals = '{7'h11, 7'h22, 7'h33, 7'h44, 7'h55};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         push_tx(vals[i]);
         if (i == 2) begin
            checks++; if (bus.pia_da !== 1'b0) begin errors++; $display("FAIL ovf_da_3: got %b expected 0", bus.pia_da); end
         end
         if (i == 3) begin
            checks++; if (bus.pia_da !== 1'b1) begin errors++; $display("FAIL ovf_da_4: got %b expected 1", bus.pia_da); end
            checks++; if (bus.tx_overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0", bus.tx_overflow); end
         end
      end
      checks++; if (bus.tx_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", bus.tx_overflow); end
      bus.fifo_txe = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n = 0;
         while (bus.fifo_wr !== 1'b0 && n < 50) begin @(negedge clk); n++; end
         checks++;
         if (bus.fifo_wr !== 1'b0 || fifo_data !== vals[i]) begin
            errors++;
            $display("FAIL drain_%0d: wr=%b data=%h expected wr=0 data=%h", i, bus.fifo_wr, fifo_data, vals[i]);
         end
         n = 0;
         while (bus.fifo_wr !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      end
      extra = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.fifo_wr === 1'b0) extra++;
      end
      checks++; if (extra != 0) begin errors++; $display("FAIL drain_extra: got %0d low cycles expected 0", extra); end
      checks++; if (bus.tx_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", bus.tx_overflow); end
      checks++; if (bus.pia_da !== 1'b0) begin errors++; $display("FAIL drain_da: got %b expected 0", bus.pia_da); end
      bus.fifo_txe = 1'b1;
   endtask

   task automatic test_alternate();
      logic seq [4];
      logic exp_seq [4];
      logic prev_rd;
      logic prev_wr;
      int ev;
      int n;
      exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
      seq     = '{1'b0, 1'b0, 1'b0, 1'b0};
      do_reset();
      push_tx(7'h61);
      push_tx(7'h62);
      tb_oe        = 1'b1;
      tb_rd_data   = 7'h70;
      bus.fifo_rxf = 1'b0;
      bus.fifo_txe = 1'b0;
      prev_rd = 1'b1;
      prev_wr = 1'b1;
      ev = 0;
      n  = 0;
      while (ev < 4 && n < 200) begin
         @(negedge clk);
         n++;
         if (prev_rd && bus.fifo_rd === 1'b0 && ev < 4) begin seq[ev] = 1'b0; ev++; end
         if (prev_wr && bus.fifo_wr === 1'b0 && ev < 4) begin seq[ev] = 1'b1; ev++; end
         prev_rd = bus.fifo_rd;
         prev_wr = bus.fifo_wr;
      end
      bus.fifo_rxf = 1'b1;
      bus.fifo_txe = 1'b1;
      checks++; if (ev != 4) begin errors++; $display("FAIL alt_count: got %0d transfers expected 4", ev); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (seq[i] !== exp_seq[i]) begin
            errors++;
            $display("FAIL alt_order_%0d: got %s expected %s", i, seq[i] ? "WR" : "RD", exp_seq[i] ? "WR" : "RD");
         end
      end
      repeat (10) @(negedge clk);
      tb_oe = 1'b0;
   endtask

   task automatic test_write_timing();
      logic          prev_wr;
      logic [DW-1:0] prev_data;
      logic          found;
      int n;
      do_reset();
      push_tx(7'h0D);
      bus.fifo_txe = 1'b0;
      prev_wr   = 1'b1;
      prev_data = '0;
      found     = 1'b0;
      n = 0;
      while (!found && n < 50) begin
         @(negedge clk);
         n++;
         if (prev_wr && bus.fifo_wr === 1'b0) found = 1'b1;
         else begin
            prev_wr   = bus.fifo_wr;
            prev_data = fifo_data;
         end
      end
      checks++; if (!found) begin errors++; $display("FAIL wt_start: fifo_wr stayed %b, expected a fall within 50 cycles", bus.fifo_wr); end
      checks++; if (prev_data !== 7'h0D) begin errors++; $display("FAIL wt_setup: got %h expected 0d", prev_data); end
      checks++; if (fifo_data !== 7'h0D) begin errors++; $display("FAIL wt_low: got %h expected 0d", fifo_data); end
      n = 0;
      while (bus.fifo_wr !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      checks++; if (fifo_data !== 7'h0D) begin errors++; $display("FAIL wt_hold: got %h expected 0d", fifo_data); end
      bus.fifo_txe = 1'b1;
      tb_probe     = 1'b1;
      @(negedge clk);
      checks++; if (fifo_data !== 7'h2A) begin errors++; $display("FAIL wt_release: got %h expected 2a", fifo_data); end
      tb_probe = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_reset_mid_write();
      test_rx_read();
      test_rx_pop();
      test_tx_overflow();
      test_alternate();
      test_write_timing();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
